alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU for the multiple-cycle CPU.
- Keeps the existing 3-bit operation encodings unchanged, extended to a 4-bit op field.
- Adds signed compare, shifts, and iterative multiply/divide, driven by a start/busy/done handshake.
- Sits in the EX stage. The control FSM holds in EX while busy is high.

Parameters:
- WIDTH, 32: operand/result width. Must be ≥4 and a power of 2.
- SH_W, $clog2(WIDTH): localparam. Shift-amount width, taken from A[SH_W-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only while busy=0
- op  in  4  operation code (see Behaviour)
- A  in  WIDTH  operand A; also the shift amount for shifts
- B  in  WIDTH  operand B
- busy  out  1  an iterative op (MUL/DIV) is in progress
- done  out  1  one-cycle pulse: res/zero/overflow updated this cycle
- res  out  WIDTH  registered result; held until the next completion
- zero  out  1  (res == 0), derived from the registered res
- overflow  out  1  signed overflow of ADD/SUB; 0 for all other ops
- illegal  out  1  registered with res; 1 if op was unassigned

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, done=0, res=0, overflow=0, illegal=0, zero=1.
  - Any in-flight iterative op is aborted. No done pulse follows.
- Operands and op are captured on the accepting edge. Later changes to A/B/op do not affect an op in flight.
- Encodings (op[3]=0 is bit-identical to legacy ops):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 NOR, 0011 XOR, 0111 SLTU (unsigned A<B → 1, else 0).
  - 0101 SRL: B >> A[SH_W-1:0].
  - 1000 SLT: signed A<B.
  - 1001 SLL: B << sh.
  - 1010 SRA: arithmetic B >>> sh.
  - 1100 MULLO, 1101 MULHU: low/high WIDTH bits of unsigned A*B.
  - 1110 DIVU, 1111 REMU: unsigned A/B, A%B.
  - 1011: illegal. Result res=0, illegal=1, same timing as single-cycle ops.
- Single-cycle ops (everything except 11xx):
  - start sampled at edge N → res/flags/done valid after edge N+1.
  - busy stays 0. done=1 for exactly one cycle.
  - Back-to-back starts give a done every cycle.
- Iterative ops (11xx), FSM IDLE → RUN → FIN → IDLE:
  - IDLE + start + op[3:2]=11 → RUN with counter = WIDTH-1. busy=1 from edge N+1.
  - RUN: one radix-2 step per cycle (shift-add multiply / restoring divide). Counter decrements. At 0 → FIN.
  - FIN: write res, pulse done, busy=0, → IDLE.
  - done therefore rises WIDTH+1 cycles after the accepting edge. busy is high for the WIDTH cycles before that.
  - start while busy=1 is ignored (no queueing). start in the FIN cycle is ignored.
  - A new start is accepted from the cycle after done.
- Divide by zero (B=0): no iteration.
  - FIN is reached in the next cycle, with single-cycle latency.
  - DIVU → all ones. REMU → A. illegal=0.
- overflow:
  - ADD: A,B same sign and res sign differs.
  - SUB: A,B different sign and res sign differs from A.
  - Cleared on every other completion.
- Widths:
  - Add/sub are modulo 2^WIDTH.
  - Shifts use only A[SH_W-1:0]; upper bits of A are ignored.
  - Product is 2*WIDTH internally.
- Between completions, res/zero/overflow/illegal hold their values. done=0.

Test Plan:
- Reset mid-MUL:
  - Stimulus: MULLO A=3 B=5, then assert rst at cycle 10 of RUN.
  - Expect: busy=0, res=0, zero=1 immediately. No done afterwards. A following ADD 1+1 returns 2 after 1 cycle.
- Legacy ops, back-to-back (WIDTH=32):
  - ADD 0x7FFFFFFF+1 → res=0x80000000, overflow=1.
  - SUB 5-5 → res=0, zero=1.
  - SLTU 1 vs 0xFFFFFFFF → 1. SLT same operands → 0.
  - NOR 0,0 → 0xFFFFFFFF.
  - One done per cycle.
- Shifts:
  - SRA B=0x80000000 sh=A=0x21 (uses sh=1) → 0xC0000000.
  - SLL B=1 A=31 → 0x80000000.
  - SRL B=0xF0 A=4 → 0x0F.
- Multiply:
  - MULLO and MULHU A=B=0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE.
  - done exactly 33 cycles after start. busy high 32 cycles.
  - A second start issued while busy is ignored.
- Divide:
  - DIVU 100/7 → 14. REMU 100/7 → 2 (33-cycle latency each).
  - DIVU 9/0 → 0xFFFFFFFF and REMU 9/0 → 9, both with done 1 cycle after start, busy never high.
- Parameter sweep:
  - WIDTH=8: MULHU 0xFF*0xFF → 0xFE, latency 9.
  - op=1011 → res=0, illegal=1, done after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [SH_W-1:0] CNT_INIT = SH_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, res_q;
  logic [SH_W-1:0]  cnt_q;
  logic             sc_q, busy_q, done_q, zero_q, ovf_q, ill_q;

  logic             accept_s, iter_s;
  logic [SH_W-1:0]  sh_s;
  logic [WIDTH-1:0] sum_s, dif_s, sc_res_d, hi_d, lo_d, fin_res_s, ddif_s;
  logic             sc_ovf_d, sc_ill_d, dge_s;
  logic [WIDTH:0]   madd_s, dsh_s;

  assign accept_s  = start && (state_q == IDLE);
  assign iter_s    = (op[3:2] == 2'b11);
  assign fin_res_s = op_q[0] ? hi_q : lo_q;

  // Result of the captured single-cycle op, written one edge after acceptance.
  always_comb begin
    sh_s     = a_q[SH_W-1:0];
    sum_s    = a_q + b_q;
    dif_s    = a_q - b_q;
    sc_res_d = '0;
    sc_ovf_d = 1'b0;
    sc_ill_d = 1'b0;
    case (op_q)
      OP_AND:  sc_res_d = a_q & b_q;
      OP_OR:   sc_res_d = a_q | b_q;
      OP_XOR:  sc_res_d = a_q ^ b_q;
      OP_NOR:  sc_res_d = ~(a_q | b_q);
      OP_ADD: begin
        sc_res_d = sum_s;
        sc_ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_d = dif_s;
        sc_ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLTU: sc_res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_SLT:  sc_res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SRL:  sc_res_d = b_q >> sh_s;
      OP_SLL:  sc_res_d = b_q << sh_s;
      OP_SRA:  sc_res_d = $signed(b_q) >>> sh_s;
      default: sc_ill_d = 1'b1;
    endcase
  end

  // One radix-2 step: {hi,lo} is the product register for MUL and {rem,quotient} for DIV.
  always_comb begin
    madd_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    dsh_s  = {hi_q, lo_q[WIDTH-1]};
    dge_s  = (dsh_s >= {1'b0, b_q});
    ddif_s = dsh_s[WIDTH-1:0] - b_q;
    if (op_q[1]) begin
      hi_d = dge_s ? ddif_s : dsh_s[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], dge_s};
    end else begin
      hi_d = madd_s[WIDTH:1];
      lo_d = {madd_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Capture, iteration FSM and registered outputs. A single-cycle completion
  // and a FIN completion can never coincide: both need IDLE one edge earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 4'b0000;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q == RUN);
      sc_q   <= accept_s && !iter_s;
      if (accept_s) begin
        op_q <= op;
        a_q  <= A;
        b_q  <= B;
      end
      if (sc_q) begin
        res_q  <= sc_res_d;
        zero_q <= (sc_res_d == '0);
        ovf_q  <= sc_ovf_d;
        ill_q  <= sc_ill_d;
        done_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept_s && iter_s) begin
            if (op[1] && (B == '0)) begin
              hi_q    <= A;
              lo_q    <= '1;
              state_q <= FIN;
            end else begin
              hi_q    <= '0;
              lo_q    <= op[1] ? A : B;
              cnt_q   <= CNT_INIT;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - SH_W'(1);
          if (cnt_q == '0) state_q <= FIN;
        end
        FIN: begin
          res_q   <= fin_res_s;
          zero_q  <= (fin_res_s == '0);
          ovf_q   <= 1'b0;
          ill_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res      = res_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: back-to-back vector table, multi-cycle corner sequences,
// an 8-bit instance, and random ops checked against an arithmetic reference.
module tb_alu_seq;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100, OP_SRL = 4'b0101, OP_SUB = 4'b0110, OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000, OP_SLL = 4'b1001, OP_SRA = 4'b1010, OP_ILL = 4'b1011;
  localparam logic [3:0] OP_MULLO = 4'b1100, OP_MULHU = 4'b1101, OP_DIVU = 4'b1110, OP_REMU = 4'b1111;

  logic        clk, rst, start, busy, done, zero, ovf, ill;
  logic [3:0]  op;
  logic [31:0] a, b, res;
  logic        start8, busy8, done8, zero8, ovf8, ill8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;

  int n_chk = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .res(res), .zero(zero), .overflow(ovf), .illegal(ill)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .res(res8), .zero(zero8), .overflow(ovf8), .illegal(ill8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference built from the arithmetic meaning of each op.
  function automatic void ref_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic v, output logic il,
                                    output int lat);
    longint            s;
    longint unsigned   p;
    int                sh;
    logic signed [31:0] sy;
    sh  = int'(x % 32);
    sy  = y;
    r   = 32'h0;
    v   = 1'b0;
    il  = 1'b0;
    lat = 1;
    p   = longint'(x) * longint'(y);
    case (o)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_ADD: begin
        s = longint'($signed(x)) + longint'($signed(y));
        r = 32'(s);
        v = (s != longint'($signed(r)));
      end
      OP_SUB: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r = 32'(s);
        v = (s != longint'($signed(r)));
      end
      OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      OP_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SRL:  r = y / (32'd1 << sh);
      OP_SLL:  r = 32'(longint'(y) * (longint'(1) << sh));
      OP_SRA:  r = sy >>> sh;
      OP_MULLO: begin r = p[31:0];  lat = 33; end
      OP_MULHU: begin r = p[63:32]; lat = 33; end
      OP_DIVU: begin r = (y == 32'd0) ? 32'hFFFFFFFF : x / y; lat = (y == 32'd0) ? 1 : 33; end
      OP_REMU: begin r = (y == 32'd0) ? x : x % y;            lat = (y == 32'd0) ? 1 : 33; end
      default: il = 1'b1;
    endcase
  endfunction

  // Issue one op, optionally fire a stray start inj cycles in, check latency and flags.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj, input string tag);
    logic [31:0] er;
    logic        ev, ei;
    int          el, lat, bc, extra;
    ref_model(o, x, y, er, ev, ei, el);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_ADD; a = $urandom; b = $urandom;
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bc++;
      start = (lat == inj);
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " busy cycles"}, 64'(bc), 64'((el == 33) ? 32 : 0));
    chk({tag, " res"}, {32'h0, res}, {32'h0, er});
    chk({tag, " zero"}, {63'h0, zero}, {63'h0, (er == 32'h0)});
    chk({tag, " overflow"}, {63'h0, ovf}, {63'h0, ev});
    chk({tag, " illegal"}, {63'h0, ill}, {63'h0, ei});
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk({tag, " extra done"}, 64'(extra), 64'd0);
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic ei, input int el, input string tag);
    int lat;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " res"}, {56'h0, res8}, {56'h0, er});
    chk({tag, " illegal"}, {63'h0, ill8}, {63'h0, ei});
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic        v, il;
  } vec_t;

  vec_t vt[15];

  initial begin
    int extra;
    vt[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
    vt[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0};
    vt[2]  = '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
    vt[3]  = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
    vt[4]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[5]  = '{OP_SRA,  32'h00000021, 32'h80000000, 32'hC0000000, 1'b0, 1'b0};
    vt[6]  = '{OP_SLL,  32'h0000001F, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    vt[7]  = '{OP_SRL,  32'h00000004, 32'h000000F0, 32'h0000000F, 1'b0, 1'b0};
    vt[8]  = '{OP_ILL,  32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b1};
    vt[9]  = '{OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
    vt[10] = '{OP_OR,   32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0};
    vt[11] = '{OP_XOR,  32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0};
    vt[12] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};
    vt[13] = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vt[14] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; op = 4'b0000; a = 32'h0; b = 32'h0;
    start8 = 1'b0; op8 = 4'b0000; a8 = 8'h0; b8 = 8'h0;
    repeat (2) @(negedge clk);
    chk("reset busy", {63'h0, busy}, 64'd0);
    chk("reset done", {63'h0, done}, 64'd0);
    chk("reset res", {32'h0, res}, 64'd0);
    chk("reset zero", {63'h0, zero}, 64'd1);
    chk("reset overflow", {63'h0, ovf}, 64'd0);
    chk("reset illegal", {63'h0, ill}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back single-cycle table: result of vector i is sampled two negedges later.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("vec%0d done", i-2), {63'h0, done}, 64'd1);
        chk($sformatf("vec%0d res", i-2), {32'h0, res}, {32'h0, vt[i-2].r});
        chk($sformatf("vec%0d zero", i-2), {63'h0, zero}, {63'h0, (vt[i-2].r == 32'h0)});
        chk($sformatf("vec%0d overflow", i-2), {63'h0, ovf}, {63'h0, vt[i-2].v});
        chk($sformatf("vec%0d illegal", i-2), {63'h0, ill}, {63'h0, vt[i-2].il});
      end
      if (i < 15) begin
        start = 1'b1; op = vt[i].op; a = vt[i].a; b = vt[i].b;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("table done drops", {63'h0, done}, 64'd0);

    run_op(OP_MULLO, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "mullo max");
    run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "mulhu max");
    run_op(OP_MULLO, 32'd3, 32'd5, 5, "mul stray start");
    run_op(OP_DIVU, 32'd100, 32'd7, -1, "divu 100/7");
    run_op(OP_REMU, 32'd100, 32'd7, 20, "remu 100/7");
    run_op(OP_DIVU, 32'd9, 32'd0, -1, "divu 9/0");
    run_op(OP_REMU, 32'd9, 32'd0, -1, "remu 9/0");

    // Reset in the middle of a multiply: immediate clear, no late done.
    run_op(OP_MULHU, 32'hFFFFFFFF, 32'h00000002, -1, "pre-reset mulhu");
    @(negedge clk);
    start = 1'b1; op = OP_MULLO; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", {63'h0, busy}, 64'd0);
    chk("midrst res", {32'h0, res}, 64'd0);
    chk("midrst zero", {63'h0, zero}, 64'd1);
    chk("midrst done", {63'h0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("midrst no done", 64'(extra), 64'd0);
    run_op(OP_ADD, 32'd1, 32'd1, -1, "post-reset add");

    run8(OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 1'b0, 9, "w8 mulhu");
    run8(OP_MULLO, 8'hFF, 8'hFF, 8'h01, 1'b0, 9, "w8 mullo");
    run8(OP_DIVU, 8'd200, 8'd7, 8'd28, 1'b0, 9, "w8 divu");
    run8(OP_REMU, 8'd200, 8'd7, 8'd4, 1'b0, 9, "w8 remu");
    run8(OP_ILL, 8'h12, 8'h34, 8'h00, 1'b1, 1, "w8 illegal");

    for (int k = 0; k < 150; k++) begin
      logic [3:0]  ro;
      logic [31:0] rx, ry;
      int          sel;
      ro  = 4'($urandom_range(0, 15));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 32'h0;
      if (sel == 1) ry = 32'($urandom_range(1, 20));
      if (sel == 2) rx = {rx[31], 31'h7FFFFFFF};
      run_op(ro, rx, ry, -1, $sformatf("rnd%0d op%0h", k, ro));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
